jt7759_cendiv: RTL and testbench

//  Parametrised clock-enable generator for the uPD7759 core. It splits the 640kHz input cen into a decoder

---
 rtl/jt7759_cendiv.sv | 101 ++++++++++
 tb/tb_jt7759_cendiv.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt7759_cendiv.sv
// Clock-enable splitter for the uPD7759 core: decoder enable plus a
// phase-locked control enable with programmable ratio and phase restart.
module jt7759_cendiv #(
  parameter int DW     = 6,
  parameter int PRE    = 2,
  parameter int MINDIV = 9,
  parameter int CTLSH  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [DW-1:0] divby,
  input  logic          sync,
  output logic          cen_ctl,
  output logic          cen_dec,
  output logic [DW-1:0] divby_l
);

  localparam int CW = DW + PRE;
  localparam logic [DW-1:0] MIN = DW'(MINDIV);
  localparam bit CTL_ALL = (CTLSH == 0);

  logic [PRE-1:0] pre_q, pre_d;
  logic [DW-1:0]  dec_q, dec_d;
  logic [DW-1:0]  dl_q, dl_d;
  logic [CW-1:0]  ctl_q, ctl_d;
  logic           octl_q, octl_d;
  logic           odec_q, odec_d;

  logic [CW-1:0]  per;
  logic [CW-1:0]  ctlp_raw;
  logic [CW-1:0]  ctlp;
  logic           eoc_pre;
  logic           eoc_dec;
  logic           eoc_ctl;

  function automatic logic [DW-1:0] clamp(
    input logic [DW-1:0] x
  );
    return (x < MIN) ? MIN : x;
  endfunction

  // Period math wraps in CW bits; a zero control period becomes 1
  always_comb begin
    per      = ({{PRE{1'b0}}, dl_q} + CW'(1)) << PRE;
    ctlp_raw = per >> CTLSH;
    ctlp     = (ctlp_raw == '0) ? CW'(1) : ctlp_raw;
    eoc_pre  = &pre_q;
    eoc_dec  = eoc_pre && (dec_q == dl_q);
    eoc_ctl  = (ctl_q == ctlp - CW'(1)) || eoc_dec;
  end

  always_comb begin
    pre_d  = pre_q;
    dec_d  = dec_q;
    dl_d   = dl_q;
    ctl_d  = ctl_q;
    octl_d = 1'b0;
    odec_d = 1'b0;
    if (sync) begin
      pre_d = '0;
      dec_d = '0;
      ctl_d = '0;
      dl_d  = clamp(divby);
    end else if (cen) begin
      pre_d = pre_q + PRE'(1);
      if (eoc_pre) begin
        dec_d = eoc_dec ? '0 : dec_q + DW'(1);
      end
      if (eoc_dec) begin
        dl_d = clamp(divby);
      end
      ctl_d  = eoc_ctl ? '0 : ctl_q + CW'(1);
      odec_d = eoc_dec;
      octl_d = CTL_ALL | eoc_ctl;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q  <= '0;
      dec_q  <= '0;
      ctl_q  <= '0;
      dl_q   <= MIN;
      octl_q <= 1'b0;
      odec_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      dec_q  <= dec_d;
      ctl_q  <= ctl_d;
      dl_q   <= dl_d;
      octl_q <= octl_d;
      odec_q <= odec_d;
    end
  end

  assign cen_ctl = octl_q;
  assign cen_dec = odec_q;
  assign divby_l = dl_q;

endmodule

// File: tb/tb_jt7759_cendiv.sv
// Bench for jt7759_cendiv: tick-index reference model, directed
// scenarios and a randomized run; second instance built with CTLSH=0.
module tb_jt7759_cendiv;

  localparam int DW = 6;
  localparam int PRE = 2;
  localparam int MINDIV = 9;
  localparam int CTLSH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b0;
  logic sync = 1'b0;
  logic [DW-1:0] divby = 6'd9;
  logic cen_ctl, cen_dec, cen_ctl0, cen_dec0;
  logic [DW-1:0] divby_l, divby_l0;

  always #5 clk = ~clk;

  jt7759_cendiv #(
    .DW(DW), .PRE(PRE), .MINDIV(MINDIV), .CTLSH(CTLSH)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .divby(divby),
    .sync(sync), .cen_ctl(cen_ctl), .cen_dec(cen_dec),
    .divby_l(divby_l)
  );

  jt7759_cendiv #(
    .DW(DW), .PRE(PRE), .MINDIV(MINDIV), .CTLSH(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .divby(divby),
    .sync(sync), .cen_ctl(cen_ctl0), .cen_dec(cen_dec0),
    .divby_l(divby_l0)
  );

  int n_checks = 0;
  int n_errs = 0;

  // model state: ticks elapsed in the current period, latched divider
  int m_t = 0;
  int m_dl = MINDIV;
  bit e_dec, e_ctl, e_ctl0;
  int g_tick, cur_tick;
  int n_dec, n_ctl;
  int dq[$];
  int cq[$];

  function automatic int clampi(input int x);
    return (x < MINDIV) ? MINDIV : x;
  endfunction

  task automatic step(input bit r, input bit s, input bit c,
                      input int d);
    int p, cp;
    rst_n = r; sync = s; cen = c; divby = DW'(d);
    e_dec = 0; e_ctl = 0; e_ctl0 = 0;
    cur_tick = -1;
    if (!r) begin
      m_t = 0; m_dl = MINDIV;
    end else if (s) begin
      m_t = 0; m_dl = clampi(d);
    end else if (c) begin
      p = (m_dl + 1) * (1 << PRE);
      cp = (p % (1 << (DW + PRE))) >> CTLSH;
      if (cp == 0) cp = 1;
      e_ctl0 = 1;
      e_dec = (m_t == p - 1);
      e_ctl = ((m_t + 1) % cp == 0) || e_dec;
      if (e_dec) begin
        m_t = 0; m_dl = clampi(d);
      end else begin
        m_t++;
      end
      cur_tick = g_tick;
      g_tick++;
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_rec();
    g_tick = 0; n_dec = 0; n_ctl = 0;
    dq.delete(); cq.delete();
  endtask

  // n cen ticks, each followed by gap idle clocks, checked every clock
  task automatic run_ticks(input string tag, input int n,
                           input int d, input int gap);
    for (int k = 0; k < n * (gap + 1); k++) begin
      step(1, 0, (k % (gap + 1)) == 0, d);
      n_checks++;
      if ({cen_dec, cen_ctl, cen_ctl0, cen_dec0, divby_l, divby_l0}
          !== {e_dec, e_ctl, e_ctl0, e_dec, DW'(m_dl), DW'(m_dl)}) begin
        n_errs++;
        $display("FAIL %s tick=%0d: dec=%b ctl=%b ctl0=%b dec0=%b dl=%0d dl0=%0d, expected dec=%b ctl=%b ctl0=%b dl=%0d",
                 tag, cur_tick, cen_dec, cen_ctl, cen_ctl0, cen_dec0,
                 divby_l, divby_l0, e_dec, e_ctl, e_ctl0, m_dl);
      end
      if (cen_dec) begin n_dec++; dq.push_back(cur_tick); end
      if (cen_ctl) begin n_ctl++; cq.push_back(cur_tick); end
    end
  endtask

  task automatic test_reset();
    step(0, 0, 1, 20);
    step(0, 0, 1, 20);
    n_checks++;
    if ({cen_dec, cen_ctl, cen_ctl0, divby_l} !== {3'b000, 6'd9}) begin
      n_errs++;
      $display("FAIL reset: dec=%b ctl=%b ctl0=%b dl=%0d, expected 0 0 0 9",
               cen_dec, cen_ctl, cen_ctl0, divby_l);
    end
    step(1, 0, 0, 9);
  endtask

  task automatic test_div9();
    clear_rec();
    run_ticks("div9", 80, 9, 3);
    n_checks++;
    if (n_dec != 2 || n_ctl != 16 || dq.size() != 2) begin
      n_errs++;
      $display("FAIL div9_count: dec=%0d ctl=%0d, expected 2 16",
               n_dec, n_ctl);
    end else begin
      n_checks++;
      if (dq[0] != 39 || dq[1] != 79) begin
        n_errs++;
        $display("FAIL div9_ticks: %0d %0d, expected 39 79", dq[0], dq[1]);
      end
    end
  endtask

  task automatic test_clamp();
    step(1, 1, 0, 9);
    clear_rec();
    run_ticks("clamp3", 80, 3, 3);
    run_ticks("clamp0", 40, 0, 3);
    n_checks++;
    if (dq.size() != 3 || divby_l !== 6'd9) begin
      n_errs++;
      $display("FAIL clamp_count: pulses=%0d dl=%0d, expected 3 9",
               dq.size(), divby_l);
    end else begin
      n_checks++;
      if (dq[0] != 39 || dq[1] != 79 || dq[2] != 119) begin
        n_errs++;
        $display("FAIL clamp_ticks: %0d %0d %0d, expected 39 79 119",
                 dq[0], dq[1], dq[2]);
      end
    end
  endtask

  task automatic test_div20_sync();
    step(1, 1, 0, 20);
    n_checks++;
    if (divby_l !== 6'd20 || cen_dec || cen_ctl) begin
      n_errs++;
      $display("FAIL sync20: dl=%0d dec=%b ctl=%b, expected 20 0 0",
               divby_l, cen_dec, cen_ctl);
    end
    clear_rec();
    run_ticks("div20", 84, 20, 3);
    n_checks++;
    if (n_dec != 1 || n_ctl != 9 || cq.size() != 9) begin
      n_errs++;
      $display("FAIL div20_count: dec=%0d ctl=%0d, expected 1 9",
               n_dec, n_ctl);
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_checks++;
        if (cq[i] != ((i < 8) ? 10 * i + 9 : 83)) begin
          n_errs++;
          $display("FAIL div20_ctl%0d: tick %0d, expected %0d",
                   i, cq[i], (i < 8) ? 10 * i + 9 : 83);
        end
      end
      n_checks++;
      if (dq[0] != 83) begin
        n_errs++;
        $display("FAIL div20_dec: tick %0d, expected 83", dq[0]);
      end
    end
  endtask

  task automatic test_midchange();
    step(1, 1, 0, 9);
    clear_rec();
    run_ticks("mid_a", 17, 9, 3);
    run_ticks("mid_b", 23, 15, 3);
    n_checks++;
    if (divby_l !== 6'd15) begin
      n_errs++;
      $display("FAIL mid_latch: dl=%0d, expected 15", divby_l);
    end
    run_ticks("mid_c", 64, 15, 3);
    n_checks++;
    if (dq.size() != 2) begin
      n_errs++;
      $display("FAIL mid_count: pulses=%0d, expected 2", dq.size());
    end else begin
      n_checks++;
      if (dq[0] != 39 || dq[1] != 103) begin
        n_errs++;
        $display("FAIL mid_ticks: %0d %0d, expected 39 103",
                 dq[0], dq[1]);
      end
    end
  endtask

  task automatic test_sync_mid();
    step(1, 1, 0, 9);
    clear_rec();
    run_ticks("syncm_a", 25, 9, 3);
    step(1, 1, 1, 9);
    n_checks++;
    if (cen_dec || cen_ctl || cen_ctl0) begin
      n_errs++;
      $display("FAIL syncm_pulse: dec=%b ctl=%b ctl0=%b, expected 0 0 0",
               cen_dec, cen_ctl, cen_ctl0);
    end
    step(1, 0, 0, 9);
    clear_rec();
    run_ticks("syncm_b", 40, 9, 3);
    n_checks++;
    if (dq.size() != 1 || (dq.size() == 1 && dq[0] != 39)) begin
      n_errs++;
      $display("FAIL syncm_period: pulses=%0d, expected one at tick 39",
               dq.size());
    end
  endtask

  task automatic test_reset_mid();
    step(1, 1, 0, 20);
    clear_rec();
    run_ticks("rstm_a", 15, 20, 3);
    step(0, 0, 1, 20);
    n_checks++;
    if ({cen_dec, cen_ctl, cen_ctl0, cen_dec0, divby_l}
        !== {4'b0000, 6'd9}) begin
      n_errs++;
      $display("FAIL rstm_state: dec=%b ctl=%b ctl0=%b dl=%0d, expected 0 0 0 9",
               cen_dec, cen_ctl, cen_ctl0, divby_l);
    end
    clear_rec();
    run_ticks("rstm_b", 40, 20, 3);
    n_checks++;
    if (dq.size() != 1 || divby_l !== 6'd20) begin
      n_errs++;
      $display("FAIL rstm_period: pulses=%0d dl=%0d, expected 1 20",
               dq.size(), divby_l);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 1, 0, 9);
    clear_rec();
    run_ticks("b2b", 80, 9, 0);
    n_checks++;
    if (n_dec != 2 || n_ctl != 16) begin
      n_errs++;
      $display("FAIL b2b_count: dec=%0d ctl=%0d, expected 2 16",
               n_dec, n_ctl);
    end
  endtask

  task automatic test_random();
    int d;
    bit r, s, c;
    d = 9;
    for (int k = 0; k < 6000; k++) begin
      r = ($urandom % 500) != 0;
      s = ($urandom % 400) == 0;
      c = ((k / 700) % 2 == 1) ? 1'b1 : (($urandom % 4) == 0);
      if (($urandom % 300) == 0) d = $urandom_range(0, 63);
      step(r, s, c, d);
      n_checks++;
      if ({cen_dec, cen_ctl, cen_ctl0, cen_dec0, divby_l, divby_l0}
          !== {e_dec, e_ctl, e_ctl0, e_dec, DW'(m_dl), DW'(m_dl)}) begin
        n_errs++;
        $display("FAIL random cyc=%0d: dec=%b ctl=%b ctl0=%b dec0=%b dl=%0d dl0=%0d, expected dec=%b ctl=%b ctl0=%b dl=%0d",
                 k, cen_dec, cen_ctl, cen_ctl0, cen_dec0, divby_l,
                 divby_l0, e_dec, e_ctl, e_ctl0, m_dl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_div9();
    test_clamp();
    test_div20_sync();
    test_midchange();
    test_sync_mid();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end

endmodule
